// File: rtl/sync_fifo_queue_if.sv
// Handshake bundle between a queue client (producer + consumer) and the
// sync_fifo_queue. The client side is the master, the queue is the slave.
interface sync_fifo_queue_if #(
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 32
);
  // enqueue side
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in;
  logic                                  request_valid_in;
  logic                                  issue_ack_out;
  // dequeue side
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out;
  logic                                  request_valid_out;
  logic                                  issue_ack_in;
  // status
  logic                                  is_empty_out;
  logic                                  is_full_out;

  modport master (
    output request_in, request_valid_in, issue_ack_in,
    input  issue_ack_out, request_out, request_valid_out, is_empty_out, is_full_out
  );

  modport slave (
    input  request_in, request_valid_in, issue_ack_in,
    output issue_ack_out, request_out, request_valid_out, is_empty_out, is_full_out
  );
endinterface

// File: rtl/sync_fifo_queue.sv
// Single-clock circular-buffer FIFO with valid/ack handshakes on both sides.
// A push is acknowledged with a one-cycle issue_ack_out pulse; a second push
// is blocked while that pulse is high so the producer has a cycle to update
// its data. All outputs are decoded from registered state only.
module sync_fifo_queue #(
  parameter int    QUEUE_SIZE                 = 16,
  parameter int    QUEUE_PTR_WIDTH_IN_BITS    = 4,
  parameter int    SINGLE_ENTRY_WIDTH_IN_BITS = 32,
  parameter string STORAGE_TYPE               = "LUTRAM"
) (
  input logic               clk_in,
  input logic               reset_in,
  sync_fifo_queue_if.slave  queue_bus
);

  localparam int PW = QUEUE_PTR_WIDTH_IN_BITS;
  localparam int W  = SINGLE_ENTRY_WIDTH_IN_BITS;

  localparam logic [PW-1:0] PTR_ONE    = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]   OCC_ONE    = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0]   OCC_ZERO   = {(PW+1){1'b0}};
  localparam logic [PW:0]   FULL_LEVEL = (PW+1)'(QUEUE_SIZE);

  logic [PW-1:0] write_ptr;
  logic [PW-1:0] read_ptr;
  logic [PW:0]   occupancy;
  logic          issue_ack;
  logic [W-1:0]  mem [QUEUE_SIZE];

  logic          is_empty;
  logic          is_full;
  logic          push;
  logic          pop;
  logic [W-1:0]  head_data;

  // Status flags and push/pop decisions, all from current registered state.
  always_comb begin
    is_empty = (occupancy == OCC_ZERO);
    is_full  = (occupancy == FULL_LEVEL);
    push     = 1'b0;
    pop      = 1'b0;
    if (queue_bus.request_valid_in && !is_full && !issue_ack) begin
      push = 1'b1;
    end else begin
      push = 1'b0;
    end
    if (queue_bus.issue_ack_in && !is_empty) begin
      pop = 1'b1;
    end else begin
      pop = 1'b0;
    end
  end

  // Pointers, occupancy and the ack pulse; reset discards every entry.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      write_ptr <= {PW{1'b0}};
      read_ptr  <= {PW{1'b0}};
      occupancy <= OCC_ZERO;
      issue_ack <= 1'b0;
    end else begin
      if (push) write_ptr <= write_ptr + PTR_ONE;
      if (pop)  read_ptr  <= read_ptr + PTR_ONE;
      issue_ack <= push;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Storage write port; contents are deliberately left unreset.
  always_ff @(posedge clk_in) begin
    if (push && !reset_in) begin
      mem[write_ptr] <= queue_bus.request_in;
    end
  end

  if (STORAGE_TYPE == "BRAM") begin : g_bram
    logic [PW-1:0] next_read_ptr;
    logic [W-1:0]  head_reg;

    assign next_read_ptr = pop ? (read_ptr + PTR_ONE) : read_ptr;

    // Registered read of the head-to-be, forwarding a same-edge write so the
    // port timing matches the asynchronous-read variant.
    always_ff @(posedge clk_in) begin
      if (push && (write_ptr == next_read_ptr)) begin
        head_reg <= queue_bus.request_in;
      end else begin
        head_reg <= mem[next_read_ptr];
      end
    end

    assign head_data = head_reg;
  end else begin : g_lutram
    assign head_data = mem[read_ptr];
  end

  // Port outputs; head data is masked to zero while the queue is empty.
  always_comb begin
    queue_bus.is_empty_out      = is_empty;
    queue_bus.is_full_out       = is_full;
    queue_bus.request_valid_out = !is_empty;
    queue_bus.issue_ack_out     = issue_ack;
    if (is_empty) begin
      queue_bus.request_out = {W{1'b0}};
    end else begin
      queue_bus.request_out = head_data;
    end
  end

endmodule

// File: tb/tb_sync_fifo_queue.sv
// Directed self-checking bench for sync_fifo_queue (default parameters).
module tb_sync_fifo_queue;

  logic clk;
  logic rst;
  int   assert_cnt;
  int   fail_cnt;
  logic [31:0] data;

  sync_fifo_queue_if #(.SINGLE_ENTRY_WIDTH_IN_BITS(32)) bus ();

  sync_fifo_queue #(
    .QUEUE_SIZE(16),
    .QUEUE_PTR_WIDTH_IN_BITS(4),
    .SINGLE_ENTRY_WIDTH_IN_BITS(32),
    .STORAGE_TYPE("LUTRAM")
  ) dut (
    .clk_in(clk),
    .reset_in(rst),
    .queue_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then let outputs settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] d);
    bus.request_in       = d;
    bus.request_valid_in = 1'b1;
    tick();
    check_value("push_ack", 32'(bus.issue_ack_out), 32'd1);
    bus.request_valid_in = 1'b0;
    tick();
    check_value("push_gap", 32'(bus.issue_ack_out), 32'd0);
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] exp);
    check_value(tag, bus.request_out, exp);
    bus.issue_ack_in = 1'b1;
    tick();
    bus.issue_ack_in = 1'b0;
  endtask

  initial begin
    assert_cnt           = 0;
    fail_cnt             = 0;
    rst                  = 1'b1;
    bus.request_in       = 32'h0000_0000;
    bus.request_valid_in = 1'b0;
    bus.issue_ack_in     = 1'b0;

    // reset state
    tick();
    tick();
    rst = 1'b0;
    check_value("rst_empty", 32'(bus.is_empty_out), 32'd1);
    check_value("rst_full", 32'(bus.is_full_out), 32'd0);
    check_value("rst_valid", 32'(bus.request_valid_out), 32'd0);
    check_value("rst_ack", 32'(bus.issue_ack_out), 32'd0);
    check_value("rst_data", bus.request_out, 32'h0000_0000);

    // fill with decrementing data, consumer idle: one ack per 2 cycles
    data                 = 32'hFFFF_FFFF;
    bus.request_in       = data;
    bus.request_valid_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_value("fill_ack", 32'(bus.issue_ack_out), 32'd1);
      if (i == 0) begin
        check_value("first_valid", 32'(bus.request_valid_out), 32'd1);
        check_value("first_data", bus.request_out, 32'hFFFF_FFFF);
        check_value("first_empty", 32'(bus.is_empty_out), 32'd0);
      end
      data           = data - 32'd1;
      bus.request_in = data;
      tick();
      check_value("fill_gap", 32'(bus.issue_ack_out), 32'd0);
    end
    check_value("full_set", 32'(bus.is_full_out), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_value("full_noack", 32'(bus.issue_ack_out), 32'd0);
      check_value("full_hold", 32'(bus.is_full_out), 32'd1);
    end

    // drain order: one pop per 16 cycles, producer refills each freed slot
    for (int k = 0; k < 4; k++) begin
      repeat (14) tick();
      check_value("drain_head", bus.request_out, 32'hFFFF_FFFF - 32'(k));
      bus.issue_ack_in = 1'b1;
      tick();
      bus.issue_ack_in = 1'b0;
      check_value("drain_ack0", 32'(bus.issue_ack_out), 32'd0);
      check_value("drain_notfull", 32'(bus.is_full_out), 32'd0);
      check_value("drain_next", bus.request_out, 32'hFFFF_FFFE - 32'(k));
      tick();
      check_value("refill_ack", 32'(bus.issue_ack_out), 32'd1);
      check_value("refill_full", 32'(bus.is_full_out), 32'd1);
      data           = data - 32'd1;
      bus.request_in = data;
    end
    bus.request_valid_in = 1'b0;

    // drain everything with the consumer acking every cycle
    bus.issue_ack_in = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check_value("drain_all", bus.request_out, 32'hFFFF_FFFB - 32'(k));
      tick();
    end
    bus.issue_ack_in = 1'b0;
    check_value("drained_empty", 32'(bus.is_empty_out), 32'd1);
    check_value("drained_data", bus.request_out, 32'h0000_0000);

    // simultaneous push and pop at occupancy 5
    for (int i = 0; i < 5; i++) push_one(32'h0000_0100 + 32'(i));
    bus.request_in       = 32'h0000_0105;
    bus.request_valid_in = 1'b1;
    bus.issue_ack_in     = 1'b1;
    tick();
    bus.request_valid_in = 1'b0;
    bus.issue_ack_in     = 1'b0;
    check_value("both_ack", 32'(bus.issue_ack_out), 32'd1);
    check_value("both_head", bus.request_out, 32'h0000_0101);
    tick();
    for (int i = 1; i < 6; i++) begin
      check_value("both_notempty", 32'(bus.is_empty_out), 32'd0);
      pop_expect("both_order", 32'h0000_0100 + 32'(i));
    end
    check_value("both_empty", 32'(bus.is_empty_out), 32'd1);

    // at full, simultaneous push+pop: push refused, occupancy 15
    for (int i = 0; i < 16; i++) push_one(32'h0000_0200 + 32'(i));
    check_value("full2_set", 32'(bus.is_full_out), 32'd1);
    bus.request_in       = 32'h0000_DEAD;
    bus.request_valid_in = 1'b1;
    bus.issue_ack_in     = 1'b1;
    tick();
    bus.request_valid_in = 1'b0;
    bus.issue_ack_in     = 1'b0;
    check_value("full2_noack", 32'(bus.issue_ack_out), 32'd0);
    check_value("full2_notfull", 32'(bus.is_full_out), 32'd0);
    check_value("full2_head", bus.request_out, 32'h0000_0201);
    tick();
    for (int i = 1; i < 16; i++) pop_expect("full2_order", 32'h0000_0200 + 32'(i));
    check_value("full2_empty", 32'(bus.is_empty_out), 32'd1);

    // many push/pop pairs across pointer wrap
    for (int i = 0; i < 40; i++) begin
      push_one(32'h0000_0300 + 32'(i));
      pop_expect("wrap_order", 32'h0000_0300 + 32'(i));
    end
    check_value("wrap_empty", 32'(bus.is_empty_out), 32'd1);

    // pop request while empty is ignored
    bus.issue_ack_in = 1'b1;
    repeat (3) tick();
    bus.issue_ack_in = 1'b0;
    check_value("idle_pop_empty", 32'(bus.is_empty_out), 32'd1);
    check_value("idle_pop_valid", 32'(bus.request_valid_out), 32'd0);
    check_value("idle_pop_full", 32'(bus.is_full_out), 32'd0);
    push_one(32'h0000_0400);
    check_value("idle_pop_head", bus.request_out, 32'h0000_0400);

    // reset at occupancy 7, with push and pop requested at the same edge
    for (int i = 1; i < 7; i++) push_one(32'h0000_0400 + 32'(i));
    rst                  = 1'b1;
    bus.request_in       = 32'h0000_0BAD;
    bus.request_valid_in = 1'b1;
    bus.issue_ack_in     = 1'b1;
    tick();
    rst                  = 1'b0;
    bus.request_valid_in = 1'b0;
    bus.issue_ack_in     = 1'b0;
    check_value("rst7_empty", 32'(bus.is_empty_out), 32'd1);
    check_value("rst7_valid", 32'(bus.request_valid_out), 32'd0);
    check_value("rst7_ack", 32'(bus.issue_ack_out), 32'd0);
    check_value("rst7_data", bus.request_out, 32'h0000_0000);
    push_one(32'h0000_0500);
    pop_expect("rst7_head", 32'h0000_0500);
    check_value("rst7_final_empty", 32'(bus.is_empty_out), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/sync_fifo_queue.md
Name: sync_fifo_queue

Overview:
- Single-clock, parameterised circular-buffer FIFO with valid/ack handshakes on both the enqueue and dequeue sides.
- Used as a generic decoupling queue between a request producer and a consumer in the pipeline/memory subsystem.
- Exposes full/empty status.
- Storage implementation (LUTRAM or BRAM) is selectable but functionally identical.

Parameters:
- QUEUE_SIZE, 16, number of entries; must be a power of two.
- QUEUE_PTR_WIDTH_IN_BITS, 4, log2(QUEUE_SIZE); width of the read/write pointers.
- SINGLE_ENTRY_WIDTH_IN_BITS, 32, data width of one entry.
- STORAGE_TYPE, "LUTRAM", storage style hint: "LUTRAM" or "BRAM". No functional or timing difference at the ports.

Ports:
- clk_in  input  1  clock; all logic is on the rising edge
- reset_in  input  1  reset, synchronous, active-high
- is_empty_out  output  1  high when occupancy == 0
- is_full_out  output  1  high when occupancy == QUEUE_SIZE
- request_in  input  SINGLE_ENTRY_WIDTH_IN_BITS  enqueue data
- request_valid_in  input  1  enqueue request; held by the producer until acked
- issue_ack_out  output  1  one-cycle pulse: request_in was captured at the previous edge
- request_out  output  SINGLE_ENTRY_WIDTH_IN_BITS  head-of-queue data
- request_valid_out  output  1  head entry is valid (== !is_empty_out)
- issue_ack_in  input  1  consumer has taken the head entry; pop it

Behaviour:
- State: write_ptr, read_ptr (QUEUE_PTR_WIDTH_IN_BITS wide, wrap modulo QUEUE_SIZE); occupancy counter (PTR width + 1 bits); storage array; issue_ack_out register.
- Reset (edge with reset_in = 1): pointers = 0, occupancy = 0, issue_ack_out = 0. Storage contents are not reset. Reset has priority over everything, including a mid-operation push or pop; it discards all entries.
- Push condition at an edge: request_valid_in && !is_full_out && !issue_ack_out.
  - On push: mem[write_ptr] <= request_in; write_ptr += 1; issue_ack_out <= 1.
  - Otherwise issue_ack_out <= 0.
  - The !issue_ack_out term prevents double-capture while the producer is still updating its data in response to the ack. Sustained push rate is therefore one entry per 2 cycles.
- Pop condition at an edge: issue_ack_in && request_valid_out. On pop, read_ptr += 1.
  - issue_ack_in while empty is ignored: no pointer or occupancy change.
- Occupancy:
  - push only: +1
  - pop only: -1
  - both at the same edge: unchanged, and both the write and the read take effect
  - Full is evaluated from current state, so no push occurs while full, even if a pop occurs at that same edge.
- Outputs are combinational from registered state only; there is no input-to-output path:
  - is_empty_out = (occupancy == 0)
  - is_full_out = (occupancy == QUEUE_SIZE)
  - request_valid_out = !is_empty_out
  - request_out = mem[read_ptr] when valid, all-zeros when empty
- Latency:
  - An entry pushed at edge k is visible on request_out/request_valid_out in the cycle after edge k, when the queue was empty.
  - Pop at edge k presents the next entry, or empty, after edge k.
- Ordering is strict FIFO. Pointer wrap from QUEUE_SIZE-1 to 0 is seamless.
- The BRAM variant must preserve identical port timing, e.g. by registering the head/next-head read internally.

Test Plan:
- Reset: assert reset_in for 1+ edges → is_empty_out=1, is_full_out=0, request_valid_out=0, issue_ack_out=0, request_out=0.
- Single push: request_in=0xFFFFFFFF, valid held → issue_ack_out pulses for exactly one cycle. Next cycle request_valid_out=1, request_out=0xFFFFFFFF, is_empty_out=0.
- Fill: producer decrements data on each ack (0xFFFFFFFF, 0xFFFFFFFE, …), consumer idle → one ack per 2 cycles. After 16 acks is_full_out=1 and issue_ack_out stays 0 while valid is held.
- Drain order: pulse issue_ack_in once per 16 cycles → request_out sequence 0xFFFFFFFF, 0xFFFFFFFE, …; the producer's next push is accepted only after a pop frees a slot.
- Simultaneous push and pop at occupancy 5 → occupancy stays 5, head advances, new tail written. At full, simultaneous push+pop → push refused, occupancy 15.
- Wrap and robustness:
  - Run more than 2×QUEUE_SIZE push/pop pairs → data order intact across pointer wrap.
  - issue_ack_in while empty → no change.
  - Reset with occupancy 7 → empty next cycle.
